// File: rtl/m_stage.sv
// ----------------------------------------------------------------------------
// m_stage : memory stage of the five-stage MIPS pipeline.
//
// The stage captures one execute-stage instruction into the M register. It
// then does one of two things:
//   - Non-memory ops pass straight to the write-back outputs one cycle later.
//   - Loads and stores run a req/ack data-memory access. The stage stalls
//     upstream (m_ready low) until the memory acknowledges.
// Store data is replicated across byte lanes with matching byte enables.
// Load data is lane-selected and then sign- or zero-extended.
//
// Optional build macro: M_STAGE_MISALIGN_TRAP_EN
//   When defined, a misaligned word or half access does not touch memory.
//   Instead it produces a write-back record with w_exc = 1 and the faulting
//   address in w_data.
//   When undefined, the low address bits are ignored for word and half
//   accesses, and w_exc is tied to 0.
// ----------------------------------------------------------------------------
module m_stage #(
    parameter logic [31:0] W_PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        e_valid,
    input  logic [31:0] e_alu_result,
    input  logic [31:0] e_rt_data,
    input  logic [3:0]  e_mem_op,
    input  logic        e_reg_write,
    input  logic [4:0]  e_dst_reg,
    input  logic [31:0] e_pc,
    input  logic        flush,
    output logic        m_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        w_valid,
    output logic        w_reg_write,
    output logic [4:0]  w_dst_reg,
    output logic [31:0] w_data,
    output logic [31:0] w_pc,
    output logic        w_exc
);

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LHU  = 4'd3;
    localparam logic [3:0] OP_LB   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SB   = 4'd8;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_PASS   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Codes 1..8 touch memory; 0 and 9..15 behave as "none".
    function automatic logic is_mem_op(input logic [3:0] op);
        logic r;
        case (op)
            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU,
            OP_SW, OP_SH, OP_SB: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        logic r;
        case (op)
            OP_SW, OP_SH, OP_SB: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

    // Loads always read the full word; the lane is selected on return.
    function automatic logic [3:0] gen_be(input logic [3:0] op, input logic [1:0] off);
        logic [3:0] r;
        case (op)
            OP_SH:   r = 4'b0011 << {off[1], 1'b0};
            OP_SB:   r = 4'b0001 << off;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    // Store data is replicated so any enabled lane already holds the value.
    function automatic logic [31:0] gen_wdata(input logic [3:0] op, input logic [31:0] rt);
        logic [31:0] r;
        case (op)
            OP_SW:   r = rt;
            OP_SH:   r = {2{rt[15:0]}};
            OP_SB:   r = {4{rt[7:0]}};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Selects the addressed lane of little-endian read data, then extends it.
    function automatic logic [31:0] load_ext(input logic [3:0]  op,
                                             input logic [1:0]  off,
                                             input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            2'd3:    b = rdata[31:24];
            default: b = rdata[7:0];
        endcase
        if (off[1]) begin
            h = rdata[31:16];
        end else begin
            h = rdata[15:0];
        end
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h00_0000, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0000, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

`ifdef M_STAGE_MISALIGN_TRAP_EN
    // A word op needs addr[1:0] == 0; a half op needs addr[0] == 0.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
        logic r;
        case (op)
            OP_LW, OP_SW:         r = (off != 2'b00);
            OP_LH, OP_LHU, OP_SH: r = off[0];
            default:              r = 1'b0;
        endcase
        return r;
    endfunction
`endif

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_t      state_r;
    logic        cap_s;
    logic        e_trap_s;
    logic        e_mem_s;
    logic        m_trap_s;

    logic [31:0] m_alu_r;
    logic [3:0]  m_op_r;
    logic        m_rw_r;
    logic [4:0]  m_dst_r;
    logic [31:0] m_pc_r;
`ifdef M_STAGE_MISALIGN_TRAP_EN
    logic        m_exc_r;
    logic        w_exc_r;
`endif

    logic        mem_req_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [3:0]  mem_be_r;
    logic [31:0] mem_wdata_r;

    logic        w_valid_r;
    logic        w_rw_r;
    logic [4:0]  w_dst_r;
    logic [31:0] w_data_r;
    logic [31:0] w_pc_r;

    // Upstream handshake, capture decision and trap classification.
    always_comb begin
        m_ready = (state_r != ST_ACCESS);
        cap_s   = m_ready & e_valid & ~flush;
`ifdef M_STAGE_MISALIGN_TRAP_EN
        e_trap_s = is_misaligned(e_mem_op, e_alu_result[1:0]);
        m_trap_s = m_exc_r;
`else
        e_trap_s = 1'b0;
        m_trap_s = 1'b0;
`endif
        e_mem_s = is_mem_op(e_mem_op) & ~e_trap_s;
    end

    // Stage FSM plus the registered memory-request outputs.
    // The request fields are loaded at capture and held for the whole access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_EMPTY;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_EMPTY, ST_PASS: begin
                    if (cap_s) begin
                        state_r   <= e_mem_s ? ST_ACCESS : ST_PASS;
                        mem_req_r <= e_mem_s;
                        if (e_mem_s) begin
                            mem_we_r    <= is_store(e_mem_op);
                            mem_addr_r  <= {e_alu_result[31:2], 2'b00};
                            mem_be_r    <= gen_be(e_mem_op, e_alu_result[1:0]);
                            mem_wdata_r <= gen_wdata(e_mem_op, e_rt_data);
                        end else begin
                            mem_we_r    <= 1'b0;
                            mem_addr_r  <= mem_addr_r;
                            mem_be_r    <= mem_be_r;
                            mem_wdata_r <= mem_wdata_r;
                        end
                    end else begin
                        state_r   <= ST_EMPTY;
                        mem_req_r <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        state_r   <= ST_EMPTY;
                        mem_req_r <= 1'b0;
                    end else begin
                        state_r   <= ST_ACCESS;
                        mem_req_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_EMPTY;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // M register: holds the captured instruction until it retires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_alu_r <= 32'h0000_0000;
            m_op_r  <= OP_NONE;
            m_rw_r  <= 1'b0;
            m_dst_r <= 5'd0;
            m_pc_r  <= 32'h0000_0000;
`ifdef M_STAGE_MISALIGN_TRAP_EN
            m_exc_r <= 1'b0;
`endif
        end else if (cap_s) begin
            m_alu_r <= e_alu_result;
            m_op_r  <= e_mem_op;
            m_rw_r  <= e_reg_write;
            m_dst_r <= e_dst_reg;
            m_pc_r  <= e_pc;
`ifdef M_STAGE_MISALIGN_TRAP_EN
            m_exc_r <= e_trap_s;
`endif
        end else begin
            m_alu_r <= m_alu_r;
        end
    end

    // Write-back record: a one-cycle w_valid pulse per retired instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_valid_r <= 1'b0;
            w_rw_r    <= 1'b0;
            w_dst_r   <= 5'd0;
            w_data_r  <= 32'h0000_0000;
            w_pc_r    <= W_PC_RESET;
`ifdef M_STAGE_MISALIGN_TRAP_EN
            w_exc_r   <= 1'b0;
`endif
        end else if (state_r == ST_PASS) begin
            w_valid_r <= 1'b1;
            w_rw_r    <= m_rw_r & ~m_trap_s;
            w_dst_r   <= m_dst_r;
            w_data_r  <= m_alu_r;
            w_pc_r    <= m_pc_r;
`ifdef M_STAGE_MISALIGN_TRAP_EN
            w_exc_r   <= m_exc_r;
`endif
        end else if ((state_r == ST_ACCESS) && mem_ack) begin
            w_valid_r <= 1'b1;
            w_rw_r    <= m_rw_r & ~is_store(m_op_r);
            w_dst_r   <= m_dst_r;
            w_data_r  <= is_store(m_op_r) ? m_alu_r
                                          : load_ext(m_op_r, m_alu_r[1:0], mem_rdata);
            w_pc_r    <= m_pc_r;
`ifdef M_STAGE_MISALIGN_TRAP_EN
            w_exc_r   <= 1'b0;
`endif
        end else begin
            w_valid_r <= 1'b0;
        end
    end

    assign mem_req     = mem_req_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_be      = mem_be_r;
    assign mem_wdata   = mem_wdata_r;
    assign w_valid     = w_valid_r;
    assign w_reg_write = w_rw_r;
    assign w_dst_reg   = w_dst_r;
    assign w_data      = w_data_r;
    assign w_pc        = w_pc_r;
`ifdef M_STAGE_MISALIGN_TRAP_EN
    assign w_exc       = w_exc_r;
`else
    assign w_exc       = 1'b0;
`endif

endmodule
